// File: rtl/systolic_ctrl.sv
// systolic_ctrl
//   Sequencer for a 4x4 output-stationary systolic array. Holds operand
//   matrices A and B (row-major, 16 elements each), loaded through a simple
//   write port. A run clears the PE accumulators and streams A into the west
//   edge and B into the north edge with diagonal skew. It then waits for the
//   array to drain and raises o_done.
//
//   Optional build macro: SYSTOLIC_CTRL_CYCCNT_EN enables the run cycle
//   counter on o_cyc_cnt. When the macro is not defined, o_cyc_cnt is tied to 0.
//
// Ports
//   i_clk, i_rst          clock (rising edge); async active-high reset
//   i_ld_en/sel/addr/data operand write: sel 0 = A, 1 = B; addr = row*4+col
//   i_start               begin a run (honoured in IDLE or DONE only)
//   o_busy, o_done        status (CLEAR/FEED/DRAIN, DONE)
//   o_arr_clr             accumulator clear pulse to the array
//   o_west0..3            A feed to array rows 0..3
//   o_north0..3           B feed to array columns 0..3
//   o_cyc_cnt             cycles spent in the last run
//
// state  | meaning
// IDLE   | waiting for start, loads accepted
// CLEAR  | one cycle of arr_clr, feeds zero
// FEED   | FEED_CYC cycles of skewed operand streaming, t = 0..FEED_CYC-1
// DRAIN  | DRAIN_CYC cycles of zero feeds while the last products settle
// DONE   | results valid in the array, loads accepted, start re-runs
module systolic_ctrl #(
    parameter int DATA_W    = 8,
    parameter int DRAIN_CYC = 1,
    parameter int FEED_CYC  = 10
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic              i_ld_en,
    input  logic              i_ld_sel,
    input  logic [3:0]        i_ld_addr,
    input  logic [DATA_W-1:0] i_ld_data,
    input  logic              i_start,
    output logic              o_busy,
    output logic              o_done,
    output logic              o_arr_clr,
    output logic [DATA_W-1:0] o_west0,
    output logic [DATA_W-1:0] o_west1,
    output logic [DATA_W-1:0] o_west2,
    output logic [DATA_W-1:0] o_west3,
    output logic [DATA_W-1:0] o_north0,
    output logic [DATA_W-1:0] o_north1,
    output logic [DATA_W-1:0] o_north2,
    output logic [DATA_W-1:0] o_north3,
    output logic [15:0]       o_cyc_cnt
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_CLEAR = 3'd1;
    localparam logic [2:0] S_FEED  = 3'd2;
    localparam logic [2:0] S_DRAIN = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    logic [2:0]        r_state;
    logic [3:0]        r_t;
    logic [7:0]        r_drain_cnt;
    logic [DATA_W-1:0] r_a [16];
    logic [DATA_W-1:0] r_b [16];
    logic              r_busy;
    logic              r_done;
    logic              r_clr;
    logic [DATA_W-1:0] r_west  [4];
    logic [DATA_W-1:0] r_north [4];

    logic [2:0]        w_state_nxt;
    logic [3:0]        w_t_nxt;
    logic [7:0]        w_drain_nxt;
    logic              w_idle_or_done;
    logic [DATA_W-1:0] w_west_nxt  [4];
    logic [DATA_W-1:0] w_north_nxt [4];

    assign w_idle_or_done = (r_state == S_IDLE) || (r_state == S_DONE);

    always_comb begin
        w_state_nxt = r_state;
        w_t_nxt     = r_t;
        w_drain_nxt = r_drain_cnt;
        case (r_state)
            S_IDLE, S_DONE: begin
                if (i_start) w_state_nxt = S_CLEAR;
            end
            S_CLEAR: begin
                w_state_nxt = S_FEED;
                w_t_nxt     = 4'd0;
            end
            S_FEED: begin
                if (r_t == 4'(FEED_CYC - 1)) begin
                    w_state_nxt = S_DRAIN;
                    w_drain_nxt = 8'(DRAIN_CYC - 1);
                end else begin
                    w_t_nxt = r_t + 4'd1;
                end
            end
            S_DRAIN: begin
                if (r_drain_cnt == 8'd0) w_state_nxt = S_DONE;
                else                     w_drain_nxt = r_drain_cnt - 8'd1;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Feeds are computed from the next state/index so the registered outputs
    // line up with the state they belong to. Row i sees A[i][t-i] and column
    // j sees B[t-j][j]. Both are zero outside the 0..3 window and outside FEED.
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            w_west_nxt[i]  = '0;
            w_north_nxt[i] = '0;
            for (int k = 0; k < 4; k++) begin
                if (w_state_nxt == S_FEED && w_t_nxt == 4'(i + k)) begin
                    w_west_nxt[i]  = r_a[4'(i * 4 + k)];
                    w_north_nxt[i] = r_b[4'(k * 4 + i)];
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_t         <= 4'd0;
            r_drain_cnt <= 8'd0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_clr       <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                r_west[2'(i)]  <= '0;
                r_north[2'(i)] <= '0;
            end
        end else begin
            r_state     <= w_state_nxt;
            r_t         <= w_t_nxt;
            r_drain_cnt <= w_drain_nxt;
            r_busy      <= (w_state_nxt == S_CLEAR) || (w_state_nxt == S_FEED)
                           || (w_state_nxt == S_DRAIN);
            r_done      <= (w_state_nxt == S_DONE);
            r_clr       <= (w_state_nxt == S_CLEAR);
            for (int i = 0; i < 4; i++) begin
                r_west[2'(i)]  <= w_west_nxt[i];
                r_north[2'(i)] <= w_north_nxt[i];
            end
        end
    end

    // Operand storage. A write that coincides with start lands at the same
    // edge that enters CLEAR, so the run sees the new value.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            for (int n = 0; n < 16; n++) begin
                r_a[4'(n)] <= '0;
                r_b[4'(n)] <= '0;
            end
        end else if (i_ld_en && w_idle_or_done) begin
            if (i_ld_sel) r_b[i_ld_addr] <= i_ld_data;
            else          r_a[i_ld_addr] <= i_ld_data;
        end
    end

`ifdef SYSTOLIC_CTRL_CYCCNT_EN
    logic [15:0] r_cyc_cnt;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_cyc_cnt <= 16'd0;
        end else if (w_idle_or_done && i_start) begin
            r_cyc_cnt <= 16'd0;
        end else if (!w_idle_or_done && r_cyc_cnt != 16'hFFFF) begin
            r_cyc_cnt <= r_cyc_cnt + 16'd1;
        end
    end

    assign o_cyc_cnt = r_cyc_cnt;
`else
    assign o_cyc_cnt = 16'd0;
`endif

    assign o_busy    = r_busy;
    assign o_done    = r_done;
    assign o_arr_clr = r_clr;
    assign o_west0   = r_west[0];
    assign o_west1   = r_west[1];
    assign o_west2   = r_west[2];
    assign o_west3   = r_west[3];
    assign o_north0  = r_north[0];
    assign o_north1  = r_north[1];
    assign o_north2  = r_north[2];
    assign o_north3  = r_north[3];

endmodule

// File: tb/tb_systolic_ctrl.sv
module tb_systolic_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        ld_en = 1'b0;
    logic        ld_sel = 1'b0;
    logic [3:0]  ld_addr = 4'd0;
    logic [7:0]  ld_data = 8'd0;
    logic        start = 1'b0;
    logic        busy, done, arr_clr;
    logic [7:0]  w0, w1, w2, w3, n0, n1, n2, n3;
    logic [15:0] cyc_cnt;

    systolic_ctrl dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_ld_en   (ld_en),
        .i_ld_sel  (ld_sel),
        .i_ld_addr (ld_addr),
        .i_ld_data (ld_data),
        .i_start   (start),
        .o_busy    (busy),
        .o_done    (done),
        .o_arr_clr (arr_clr),
        .o_west0   (w0),
        .o_west1   (w1),
        .o_west2   (w2),
        .o_west3   (w3),
        .o_north0  (n0),
        .o_north1  (n1),
        .o_north2  (n2),
        .o_north3  (n3),
        .o_cyc_cnt (cyc_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // reference operand matrices, row-major
    logic [7:0] mA [16];
    logic [7:0] mB [16];
    // feeds captured during t = 0..9
    logic [7:0] cw [10][4];
    logic [7:0] cn [10][4];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [7:0] exp_west(input int i, input int t);
        if (t >= 0 && t <= 9 && t - i >= 0 && t - i <= 3) return mA[i * 4 + t - i];
        return 8'd0;
    endfunction

    function automatic logic [7:0] exp_north(input int j, input int t);
        if (t >= 0 && t <= 9 && t - j >= 0 && t - j <= 3) return mB[(t - j) * 4 + j];
        return 8'd0;
    endfunction

    // n = cycles since the start edge; CLEAR is n=1, DONE from n=13
    function automatic logic [15:0] exp_cyc(input int n);
`ifdef SYSTOLIC_CTRL_CYCCNT_EN
        return 16'((n > 13) ? 12 : n - 1);
`else
        return 16'(n - n);
`endif
    endfunction

    task automatic load(input bit sel, input int addr, input logic [7:0] d);
        ld_en = 1'b1; ld_sel = sel; ld_addr = 4'(addr); ld_data = d;
        if (sel) mB[addr] = d; else mA[addr] = d;
        @(negedge clk);
        ld_en = 1'b0;
    endtask

    task automatic push_model();
        for (int n = 0; n < 16; n++) load(1'b0, n, mA[n]);
        for (int n = 0; n < 16; n++) load(1'b1, n, mB[n]);
    endtask

    task automatic rand_model();
        for (int n = 0; n < 16; n++) begin
            mA[n] = 8'($urandom_range(0, 255));
            mB[n] = 8'($urandom_range(0, 255));
        end
    endtask

    // Pulses start (optionally with a coincident write) and checks 33 cycles.
    // At feed index inj_t, an A[0]=FF write and a second start are presented;
    // both must be ignored. The reference model is not updated for them.
    task automatic run(input string tag, input int inj_t, input bit co_wr,
                       input bit co_sel, input int co_addr, input logic [7:0] co_data);
        logic [7:0]  ow [4];
        logic [7:0]  on [4];
        logic [15:0] ref_c, obs_c;
        int t;
        start = 1'b1;
        if (co_wr) begin
            ld_en = 1'b1; ld_sel = co_sel; ld_addr = 4'(co_addr); ld_data = co_data;
            if (co_sel) mB[co_addr] = co_data; else mA[co_addr] = co_data;
        end
        for (int n = 1; n <= 33; n++) begin
            @(negedge clk);
            start = 1'b0;
            ld_en = 1'b0;
            ow = '{w0, w1, w2, w3};
            on = '{n0, n1, n2, n3};
            t = n - 2;
            chk($sformatf("%s busy@%0d", tag, n), 32'(busy), 32'(n <= 12));
            chk($sformatf("%s done@%0d", tag, n), 32'(done), 32'(n >= 13));
            chk($sformatf("%s clr@%0d", tag, n), 32'(arr_clr), 32'(n == 1));
            chk($sformatf("%s cyc@%0d", tag, n), 32'(cyc_cnt), 32'(exp_cyc(n)));
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("%s west%0d@t%0d", tag, i, t), 32'(ow[i]), 32'(exp_west(i, t)));
                chk($sformatf("%s north%0d@t%0d", tag, i, t), 32'(on[i]), 32'(exp_north(i, t)));
                if (t >= 0 && t <= 9) begin
                    cw[t][i] = ow[i];
                    cn[t][i] = on[i];
                end
            end
            if (n == inj_t + 2) begin
                ld_en = 1'b1; ld_sel = 1'b0; ld_addr = 4'd0; ld_data = 8'hFF;
                start = 1'b1;
            end
        end
        // PE(i,j) sees west_i delayed by j and north_j delayed by i. Summing
        // the captured streams that way must give A*B (16-bit wrap).
        for (int i = 0; i < 4; i++) begin
            for (int j = 0; j < 4; j++) begin
                ref_c = 16'd0;
                obs_c = 16'd0;
                for (int k = 0; k < 4; k++) ref_c = ref_c + 16'(mA[i * 4 + k]) * 16'(mB[k * 4 + j]);
                for (int tau = 0; tau < 16; tau++) begin
                    if (tau - j >= 0 && tau - j <= 9 && tau - i >= 0 && tau - i <= 9)
                        obs_c = obs_c + 16'(cw[tau - j][i]) * 16'(cn[tau - i][j]);
                end
                chk($sformatf("%s prod%0d%0d", tag, i, j), 32'(obs_c), 32'(ref_c));
            end
        end
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " clr"}, 32'(arr_clr), 32'd0);
        chk({tag, " cyc"}, 32'(cyc_cnt), 32'd0);
        chk({tag, " feeds"}, {w0, w1, w2, w3}, 32'd0);
        chk({tag, " feedsn"}, {n0, n1, n2, n3}, 32'd0);
    endtask

    initial begin
        for (int n = 0; n < 16; n++) begin mA[n] = 8'd0; mB[n] = 8'd0; end
        repeat (2) @(negedge clk);
        chk_zero("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_zero("idle");

        // identity A, B = 1..16
        for (int n = 0; n < 16; n++) begin
            mA[n] = (n % 5 == 0) ? 8'd1 : 8'd0;
            mB[n] = 8'(n + 1);
        end
        push_model();
        run("ident", -10, 1'b0, 1'b0, 0, 8'd0);

        // skew pattern
        for (int n = 0; n < 16; n++) begin
            mA[n] = 8'(16 * (n / 4) + n % 4);
            mB[n] = 8'd1;
        end
        push_model();
        run("skew", -10, 1'b0, 1'b0, 0, 8'd0);

        // back-to-back from DONE; B[15] arrives together with start
        for (int n = 0; n < 16; n++) begin
            mA[n] = 8'd2;
            mB[n] = (n == 15) ? 8'd0 : 8'd3;
        end
        push_model();
        run("b2b", -10, 1'b1, 1'b1, 15, 8'd3);

        // write and start while busy, then rerun without reloading
        rand_model();
        push_model();
        run("busywr", 3, 1'b0, 1'b0, 0, 8'd0);
        run("busywr2", -10, 1'b0, 1'b0, 0, 8'd0);

        repeat (2) begin
            rand_model();
            push_model();
            run("rand", -10, 1'b0, 1'b0, 0, 8'd0);
        end

        // async reset at feed index t=5
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (6) @(negedge clk);
        chk("midrst pre busy", 32'(busy), 32'd1);
        #2 rst = 1'b1;
        #1 chk_zero("midrst");
        @(negedge clk);
        chk_zero("midrst held");
        rst = 1'b0;
        for (int n = 0; n < 16; n++) begin mA[n] = 8'd0; mB[n] = 8'd0; end
        run("postrst_zero", -10, 1'b0, 1'b0, 0, 8'd0);
        rand_model();
        push_model();
        run("postrst", -10, 1'b0, 1'b0, 0, 8'd0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
